uart_rx_deser_param: RTL
========================

Name: uart_rx_deser_param

Overview:
Parametrised, fully synchronous deserializer for the UART receive path. It collects sampled data bits into a word of configurable width and bit order. It flags each completed word with a one-cycle valid strobe and holds an unread/overrun status until the consumer acknowledges. It sits between the data sampler and the RX FSM/parity and stop checkers, and replaces the bit-count-indexed combinational deserializer.

Parameters:
DATA_WIDTH, 8, word length in bits; legal range 5..9.
MSB_FIRST, 0, bit order: 0 = first received bit lands in P_data[0]; 1 = first received bit lands in P_data[DATA_WIDTH-1].
CNT_WIDTH, 4, width of the internal bit counter; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
CLK  input  1  system clock; all state changes on the rising edge.
RST  input  1  asynchronous, active-low reset.
deser_en  input  1  data-bit window from the RX FSM; high only while data bits are being received.
sample_valid  input  1  one-cycle strobe from the sampler; sampled_bit is valid in this cycle.
sampled_bit  input  1  majority-voted bit value.
clear  input  1  synchronous abort (framing error or break); discards any partial word.
data_ack  input  1  consumer has read P_data; clears the unread flag.
P_data  output  DATA_WIDTH  last completed word; registered.
data_valid  output  1  one-cycle pulse; a new word is present on P_data.
unread  output  1  high from data_valid until data_ack.
overrun  output  1  sticky; a word completed while the previous word was unread.
busy  output  1  partial word in progress (bit count != 0).
bit_cnt  output  CNT_WIDTH  number of bits accepted in the current word.

Behaviour:
- Reset (RST low, asynchronous):
  - P_data=0, shift register=0, bit_cnt=0.
  - data_valid=0, unread=0, overrun=0, busy=0.
- Accept condition: deser_en && sample_valid && !clear.
  - Accepted bit is shifted into the internal shift register.
  - MSB_FIRST=0: shift right, new bit enters at [DATA_WIDTH-1].
  - MSB_FIRST=1: shift left, new bit enters at [0].
  - bit_cnt increments by 1 per accepted bit.
- Completion: an accept with bit_cnt==DATA_WIDTH-1 completes the word.
  - On that edge: P_data <= final assembled word (including the current bit), bit_cnt <= 0.
  - Also on that edge: data_valid <= 1 for exactly one cycle, unread <= 1.
  - Latency: P_data and data_valid are visible the cycle after the final sample_valid.
- P_data holds its value between completions and is never changed by a partial word, clear, or deser_en drop.
- busy = (bit_cnt != 0), combinational from the register.
- deser_en low while bit_cnt != 0: partial word discarded, bit_cnt <= 0, no data_valid. sample_valid while deser_en is low is ignored.
- clear high: bit_cnt <= 0, shift register <= 0, no data_valid. clear has priority over an accept in the same cycle. clear does not affect P_data, unread, or overrun.
- data_ack: unread <= 0 and overrun <= 0 on the next edge.
- Completion while unread=1 and data_ack=0: P_data is overwritten with the new word, overrun <= 1, unread stays 1.
- Completion and data_ack in the same cycle: the ack applies to the old word. Result: unread=1, overrun not set, and overrun=0 because data_ack clears it.
- bit_cnt never exceeds DATA_WIDTH-1 and has no wrap-around beyond the completion reset.
- RST asserted mid-word: everything returns to reset values immediately, independent of CLK.

Test Plan:
- DATA_WIDTH=8, MSB_FIRST=0, bits 1,0,1,0,0,1,0,1 (first to last) -> P_data=8'hA5 and data_valid high one cycle after the 8th strobe; unread=1.
- Same bit stream with MSB_FIRST=1 -> P_data=8'hA5 reversed, i.e. 8'hA5 becomes 8'b10100101 read MSB-first = 8'hA5 bit-reversed (8'hA5); also send 1,1,0,0,0,0,0,0 -> P_data=8'hC0 (MSB_FIRST=1) versus 8'h03 (MSB_FIRST=0).
- DATA_WIDTH=7, 7 bits of 1 -> P_data=7'h7F; bit_cnt sequence 1..6 then 0; busy low after completion.
- After 4 bits, pulse clear (and separately drop deser_en) -> bit_cnt=0, no data_valid, P_data keeps the prior word; a fresh 8-bit word then completes normally.
- Complete word 8'h11 without ack, then word 8'h22 -> P_data=8'h22, overrun=1; data_ack -> unread=0, overrun=0. Repeat with data_ack on the completion cycle -> overrun stays 0, unread=1.
- Assert RST low mid-word (bit_cnt=5) between clock edges -> all outputs 0 immediately; after release the next 8 bits form a clean word.

Source files
------------

// File: rtl/uart_rx_deser_param.sv
// uart_rx_deser_param: collects sampled UART data bits into a word with a valid strobe and unread/overrun status
module uart_rx_deser_param #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  deser_en,
  input  logic                  sample_valid,
  input  logic                  sampled_bit,
  input  logic                  clear,
  input  logic                  data_ack,
  output logic [DATA_WIDTH-1:0] P_data,
  output logic                  data_valid,
  output logic                  unread,
  output logic                  overrun,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  bit_cnt
);
  logic [DATA_WIDTH-1:0] r_shift, r_data, w_shift_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_valid, r_unread, r_overrun;
  logic                  w_accept, w_done;
  assign w_accept    = deser_en && sample_valid && !clear;
  assign w_done      = w_accept && (r_cnt == CNT_WIDTH'(DATA_WIDTH - 1));
  assign w_shift_nxt = MSB_FIRST ? {r_shift[DATA_WIDTH-2:0], sampled_bit}
                                 : {sampled_bit, r_shift[DATA_WIDTH-1:1]};
  assign P_data      = r_data;
  assign data_valid  = r_valid;
  assign unread      = r_unread;
  assign overrun     = r_overrun;
  assign bit_cnt     = r_cnt;
  assign busy        = r_cnt != '0;
  // shift in accepted bits, publish completed words, track unread/overrun; an ack on the completion edge applies to the old word
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_shift   <= '0;
      r_data    <= '0;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_unread  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid <= w_done;
      if (clear || !deser_en) begin
        r_cnt   <= '0;
        r_shift <= '0;
      end else if (w_done) begin
        r_cnt   <= '0;
        r_shift <= w_shift_nxt;
        r_data  <= w_shift_nxt;
      end else if (w_accept) begin
        r_cnt   <= r_cnt + CNT_WIDTH'(1);
        r_shift <= w_shift_nxt;
      end
      r_unread  <= w_done | (r_unread & ~data_ack);
      r_overrun <= ~data_ack & (r_overrun | (w_done & r_unread));
    end
  end
endmodule
